// File: rtl/wd_bus_sequencer.sv
// -----------------------------------------------------------------------------
// wd_bus_sequencer
// Sole master of the watchdog ABUS/DBUS write port. Arbitrates between an
// internal auto-service timer, a manual service requester and a configuration
// requester, and emits the unlock-key-then-data write sequence followed by one
// idle recovery cycle.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_srv_req      level service request, held until o_srv_ack
//   i_cfg_req      level configuration request, held until o_cfg_ack/o_cfg_err
//   i_cfg_addr     configuration target address (stable while i_cfg_req)
//   i_cfg_data     configuration data (stable while i_cfg_req)
//   i_auto_en      auto-service timer enable
//   i_auto_period  auto-service period in cycles, 0 disables the timer
//   o_abus         watchdog address bus
//   o_dbus         watchdog data bus
//   o_busy         sequence in progress (KEY, DATA or RECOVER bus cycle)
//   o_srv_ack      manual service completed (DATA cycle)
//   o_cfg_ack      configuration write completed (DATA cycle)
//   o_cfg_err      configuration request to the reserved status address
//   o_auto_miss    auto period expired while the previous one was unserved
// All outputs are registered from the current state, so a bus cycle appears
// one clock after the state that produces it.
// -----------------------------------------------------------------------------
module wd_bus_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_srv_req,
    input  logic             i_cfg_req,
    input  logic [1:0]       i_cfg_addr,
    input  logic [7:0]       i_cfg_data,
    input  logic             i_auto_en,
    input  logic [CNT_W-1:0] i_auto_period,
    output logic [1:0]       o_abus,
    output logic [7:0]       o_dbus,
    output logic             o_busy,
    output logic             o_srv_ack,
    output logic             o_cfg_ack,
    output logic             o_cfg_err,
    output logic             o_auto_miss
);

    localparam logic [7:0] UNLOCK_KEY = 8'h5A;
    localparam logic [1:0] SRVC_ADDR  = 2'b11;
    localparam logic [7:0] SRVC_DATA  = 8'h01;
    localparam logic [7:0] IDLE_DATA  = 8'h00;
    localparam logic [1:0] STAT_ADDR  = 2'b10;
    localparam logic [1:0] IDLE_ADDR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_KEY     = 2'd1,
        ST_DATA    = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TX_AUTO = 2'd0,
        TX_SRV  = 2'd1,
        TX_CFG  = 2'd2
    } txn_t;

    state_t           r_state;
    state_t           w_state_nxt;
    txn_t             r_txn;
    txn_t             w_txn_nxt;
    logic [1:0]       r_addr;
    logic [1:0]       w_addr_nxt;
    logic [7:0]       r_data;
    logic [7:0]       w_data_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_auto_pend;
    logic             w_auto_pend_nxt;

    logic [1:0]       w_abus;
    logic [7:0]       w_dbus;
    logic             w_busy;
    logic             w_srv_ack;
    logic             w_cfg_ack;
    logic             w_cfg_err;
    logic             w_auto_miss;
    logic             w_svc_done;
    logic             w_timer_on;
    logic             w_wrap;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration, next state and bus cycle decode for the current state
    always_comb begin
        w_state_nxt = r_state;
        w_txn_nxt   = r_txn;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_abus      = IDLE_ADDR;
        w_dbus      = IDLE_DATA;
        w_busy      = 1'b0;
        w_srv_ack   = 1'b0;
        w_cfg_ack   = 1'b0;
        w_cfg_err   = 1'b0;
        w_svc_done  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_auto_pend) begin
                    w_txn_nxt   = TX_AUTO;
                    w_addr_nxt  = SRVC_ADDR;
                    w_data_nxt  = SRVC_DATA;
                    w_state_nxt = ST_KEY;
                end else if (i_srv_req) begin
                    w_txn_nxt   = TX_SRV;
                    w_addr_nxt  = SRVC_ADDR;
                    w_data_nxt  = SRVC_DATA;
                    w_state_nxt = ST_KEY;
                end else if (i_cfg_req) begin
                    // The status address belongs to the watchdog itself
                    if (i_cfg_addr == STAT_ADDR) begin
                        w_cfg_err = 1'b1;
                    end else begin
                        w_txn_nxt   = TX_CFG;
                        w_addr_nxt  = i_cfg_addr;
                        w_data_nxt  = i_cfg_data;
                        w_state_nxt = ST_KEY;
                    end
                end
            end
            ST_KEY: begin
                w_abus      = r_addr;
                w_dbus      = UNLOCK_KEY;
                w_busy      = 1'b1;
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_abus      = r_addr;
                w_dbus      = r_data;
                w_busy      = 1'b1;
                w_srv_ack   = (r_txn == TX_SRV);
                w_cfg_ack   = (r_txn == TX_CFG);
                w_svc_done  = (r_txn != TX_CFG);
                w_state_nxt = ST_RECOVER;
            end
            ST_RECOVER: begin
                w_busy      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Auto-service timer; a service completing this cycle satisfies any
    // expiry seen in the same cycle, so it neither sets pending nor misses
    always_comb begin
        w_timer_on      = i_auto_en && (i_auto_period != '0);
        w_wrap          = w_timer_on && (r_cnt >= (i_auto_period - CNT_W'(1)));
        w_cnt_nxt       = r_cnt + CNT_W'(1);
        w_auto_pend_nxt = r_auto_pend;
        w_auto_miss     = 1'b0;

        if (!w_timer_on || w_svc_done || w_wrap) begin
            w_cnt_nxt = '0;
        end

        if (w_svc_done) begin
            w_auto_pend_nxt = 1'b0;
        end else if (w_wrap) begin
            w_auto_pend_nxt = 1'b1;
            w_auto_miss     = r_auto_pend;
        end
    end

    // Transaction latch, timer and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_txn       <= TX_AUTO;
            r_addr      <= IDLE_ADDR;
            r_data      <= IDLE_DATA;
            r_cnt       <= '0;
            r_auto_pend <= 1'b0;
            o_abus      <= IDLE_ADDR;
            o_dbus      <= IDLE_DATA;
            o_busy      <= 1'b0;
            o_srv_ack   <= 1'b0;
            o_cfg_ack   <= 1'b0;
            o_cfg_err   <= 1'b0;
            o_auto_miss <= 1'b0;
        end else begin
            r_txn       <= w_txn_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_cnt       <= w_cnt_nxt;
            r_auto_pend <= w_auto_pend_nxt;
            o_abus      <= w_abus;
            o_dbus      <= w_dbus;
            o_busy      <= w_busy;
            o_srv_ack   <= w_srv_ack;
            o_cfg_ack   <= w_cfg_ack;
            o_cfg_err   <= w_cfg_err;
            o_auto_miss <= w_auto_miss;
        end
    end

endmodule
